alu_operand_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the 64-bit ALU. It registers decoded operands and control from the decode stage, then resolves data forwarding from the EX/MEM and MEM/WB stages. It drives the ALU's `a`, `b` and `op` inputs and flags load-use hazards back to decode. It supports stall (hold) and flush (bubble insertion).

---
 rtl/alu_operand_stage.sv | 173 +++++++++++++++++
 tb/tb_alu_operand_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: registers decoded operands/control, resolves EX/MEM and MEM/WB
// forwarding for the ALU inputs, and flags load-use hazards back to decode.
module alu_operand_stage #(
  parameter int unsigned W  = 64,
  parameter int unsigned RA = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [W-1:0]  id_rn_data,
  input  logic [W-1:0]  id_rm_data,
  input  logic [W-1:0]  id_imm,
  input  logic [RA-1:0] id_rn_addr,
  input  logic [RA-1:0] id_rm_addr,
  input  logic [RA-1:0] id_rd_addr,
  input  logic          id_alu_src,
  input  logic [3:0]    id_alu_op,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          stall,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RA-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RA-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_data,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_op,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [RA-1:0] ex_rd,
  output logic [W-1:0]  ex_store_data,
  output logic          load_use_hazard
);

  localparam logic [RA-1:0] Xzr   = RA'(31);
  localparam logic [3:0]    OpAnd = 4'b0000;

  logic          valid_q, valid_d;
  logic [W-1:0]  rn_data_q, rn_data_d;
  logic [W-1:0]  rm_data_q, rm_data_d;
  logic [W-1:0]  imm_q, imm_d;
  logic [RA-1:0] rn_addr_q, rn_addr_d;
  logic [RA-1:0] rm_addr_q, rm_addr_d;
  logic [RA-1:0] rd_addr_q, rd_addr_d;
  logic          alu_src_q, alu_src_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;

  // Flush beats stall; a stall simply leaves every field at its held value.
  always_comb begin
    valid_d     = valid_q;
    rn_data_d   = rn_data_q;
    rm_data_d   = rm_data_q;
    imm_d       = imm_q;
    rn_addr_d   = rn_addr_q;
    rm_addr_d   = rm_addr_q;
    rd_addr_d   = rd_addr_q;
    alu_src_d   = alu_src_q;
    alu_op_d    = alu_op_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (flush) begin
      valid_d     = 1'b0;
      rn_data_d   = '0;
      rm_data_d   = '0;
      imm_d       = '0;
      rn_addr_d   = '0;
      rm_addr_d   = '0;
      rd_addr_d   = '0;
      alu_src_d   = 1'b0;
      alu_op_d    = OpAnd;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!stall) begin
      valid_d     = id_valid;
      rn_data_d   = id_rn_data;
      rm_data_d   = id_rm_data;
      imm_d       = id_imm;
      rn_addr_d   = id_rn_addr;
      rm_addr_d   = id_rm_addr;
      rd_addr_d   = id_rd_addr;
      alu_src_d   = id_alu_src;
      alu_op_d    = id_alu_op;
      // An invalid slot must never produce side effects downstream.
      reg_write_d = id_valid & id_reg_write;
      mem_read_d  = id_valid & id_mem_read;
      mem_write_d = id_valid & id_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rn_data_q   <= '0;
      rm_data_q   <= '0;
      imm_q       <= '0;
      rn_addr_q   <= '0;
      rm_addr_q   <= '0;
      rd_addr_q   <= '0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= OpAnd;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rn_data_q   <= rn_data_d;
      rm_data_q   <= rm_data_d;
      imm_q       <= imm_d;
      rn_addr_q   <= rn_addr_d;
      rm_addr_q   <= rm_addr_d;
      rd_addr_q   <= rd_addr_d;
      alu_src_q   <= alu_src_d;
      alu_op_q    <= alu_op_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  logic rn_hit_ex, rn_hit_wb, rm_hit_ex, rm_hit_wb;
  logic [W-1:0] rn_fwd, rm_fwd;

  // XZR always reads as its registered value; EX/MEM is the younger producer.
  always_comb begin
    rn_hit_ex = exmem_reg_write && (exmem_rd == rn_addr_q) && (rn_addr_q != Xzr);
    rn_hit_wb = memwb_reg_write && (memwb_rd == rn_addr_q) && (rn_addr_q != Xzr);
    rm_hit_ex = exmem_reg_write && (exmem_rd == rm_addr_q) && (rm_addr_q != Xzr);
    rm_hit_wb = memwb_reg_write && (memwb_rd == rm_addr_q) && (rm_addr_q != Xzr);

    rn_fwd = rn_data_q;
    if (rn_hit_ex) begin
      rn_fwd = exmem_result;
    end else if (rn_hit_wb) begin
      rn_fwd = memwb_data;
    end

    rm_fwd = rm_data_q;
    if (rm_hit_ex) begin
      rm_fwd = exmem_result;
    end else if (rm_hit_wb) begin
      rm_fwd = memwb_data;
    end
  end

  always_comb begin
    alu_a         = rn_fwd;
    alu_b         = alu_src_q ? imm_q : rm_fwd;
    ex_store_data = rm_fwd;
    alu_op        = alu_op_q;
    ex_valid      = valid_q;
    ex_reg_write  = reg_write_q;
    ex_mem_read   = mem_read_q;
    ex_mem_write  = mem_write_q;
    ex_rd         = rd_addr_q;
  end

  always_comb begin
    load_use_hazard = valid_q && mem_read_q && (rd_addr_q != Xzr) && id_valid &&
                      ((rd_addr_q == id_rn_addr) || (rd_addr_q == id_rm_addr));
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: a stage-level model checked every cycle, plus directed
// vectors with hand-computed expectations.
module tb_alu_operand_stage;

  localparam int W  = 64;
  localparam int RA = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [W-1:0]  id_rn_data, id_rm_data, id_imm;
  logic [RA-1:0] id_rn_addr, id_rm_addr, id_rd_addr;
  logic          id_alu_src;
  logic [3:0]    id_alu_op;
  logic          id_reg_write, id_mem_read, id_mem_write;
  logic          stall, flush;
  logic          exmem_reg_write;
  logic [RA-1:0] exmem_rd;
  logic [W-1:0]  exmem_result;
  logic          memwb_reg_write;
  logic [RA-1:0] memwb_rd;
  logic [W-1:0]  memwb_data;
  logic [W-1:0]  alu_a, alu_b, ex_store_data;
  logic [3:0]    alu_op;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [RA-1:0] ex_rd;
  logic          load_use_hazard;

  alu_operand_stage #(.W(W), .RA(RA)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rn_data      (id_rn_data),
    .id_rm_data      (id_rm_data),
    .id_imm          (id_imm),
    .id_rn_addr      (id_rn_addr),
    .id_rm_addr      (id_rm_addr),
    .id_rd_addr      (id_rd_addr),
    .id_alu_src      (id_alu_src),
    .id_alu_op       (id_alu_op),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .stall           (stall),
    .flush           (flush),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_data      (memwb_data),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_op          (alu_op),
    .ex_valid        (ex_valid),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_rd           (ex_rd),
    .ex_store_data   (ex_store_data),
    .load_use_hazard (load_use_hazard)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the instruction currently held in the stage.
  typedef struct packed {
    logic          valid;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic [3:0]    op;
    logic [RA-1:0] rn, rm, rd;
    logic [W-1:0]  rn_data, rm_data, imm;
  } stage_t;

  stage_t m;
  logic   model_ok = 1'b0;

  always @(posedge clk) begin
    model_ok <= 1'b1;
    if (!rst_n || flush) m <= '0;
    else if (!stall)
      m <= '{valid: id_valid, alu_src: id_alu_src, reg_write: id_valid & id_reg_write,
             mem_read: id_valid & id_mem_read, mem_write: id_valid & id_mem_write,
             op: id_alu_op, rn: id_rn_addr, rm: id_rm_addr, rd: id_rd_addr,
             rn_data: id_rn_data, rm_data: id_rm_data, imm: id_imm};
  end

  function automatic logic [W-1:0] value_of(input logic [RA-1:0] r, input logic [W-1:0] d);
    if (r == 5'd31) return d;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_data;
    return d;
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_alu_a", alu_a, value_of(m.rn, m.rn_data));
      chk("m_alu_b", alu_b, m.alu_src ? m.imm : value_of(m.rm, m.rm_data));
      chk("m_store", ex_store_data, value_of(m.rm, m.rm_data));
      chk("m_op", W'(alu_op), W'(m.op));
      chk("m_ctl", W'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}),
          W'({m.valid, m.reg_write, m.mem_read, m.mem_write}));
      chk("m_rd", W'(ex_rd), W'(m.rd));
      chk("m_hazard", W'(load_use_hazard),
          W'(m.valid && m.mem_read && m.rd != 5'd31 && id_valid &&
             (m.rd == id_rn_addr || m.rd == id_rm_addr)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [RA-1:0] rn, input logic [RA-1:0] rm,
                        input logic [RA-1:0] rd, input logic [W-1:0] rnd,
                        input logic [W-1:0] rmd, input logic [W-1:0] imm, input logic src,
                        input logic [3:0] op, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rn_addr = rn; id_rm_addr = rm; id_rd_addr = rd;
    id_rn_data = rnd; id_rm_data = rmd; id_imm = imm; id_alu_src = src;
    id_alu_op = op; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_random_id();
    set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  function automatic logic [RA-1:0] pick_reg();
    int unsigned r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_data = '0;
    set_random_id();

    // Reset with garbage on the decode side.
    tick(); set_random_id(); tick();
    chk("rst_valid", W'(ex_valid), '0);
    chk("rst_op", W'(alu_op), '0);
    chk("rst_rw", W'(ex_reg_write), '0);
    chk("rst_rd", W'(ex_rd), '0);
    chk("rst_alu_a", alu_a, '0);

    // ADD X1,X2,X3
    rst_n = 1'b1;
    set_id(1, 2, 3, 1, 5, 7, 0, 0, 4'b0010, 1, 0, 0);
    tick();
    chk("add_a", alu_a, 64'd5);
    chk("add_b", alu_b, 64'd7);
    chk("add_op", W'(alu_op), W'(4'b0010));
    chk("add_valid", W'(ex_valid), 1);

    // Forwarding priority on Rn=4
    set_id(1, 4, 5, 10, 1, 2, 0, 0, 4'b0001, 1, 0, 0);
    tick();
    stall = 1'b1;
    exmem_reg_write = 1; exmem_rd = 4; exmem_result = 64'hAA;
    memwb_reg_write = 1; memwb_rd = 4; memwb_data = 64'hBB;
    #1 chk("fwd_ex", alu_a, 64'hAA);
    exmem_reg_write = 0;
    #1 chk("fwd_wb", alu_a, 64'hBB);
    memwb_reg_write = 0;
    #1 chk("fwd_none", alu_a, 64'd1);

    // Rn==Rm both forwarded
    stall = 1'b0;
    set_id(1, 6, 6, 11, 3, 4, 0, 0, 4'b0010, 1, 0, 0);
    tick();
    stall = 1'b1;
    memwb_reg_write = 1; memwb_rd = 6; memwb_data = 64'h55;
    #1 chk("same_a", alu_a, 64'h55);
    chk("same_b", alu_b, 64'h55);
    chk("same_st", ex_store_data, 64'h55);
    memwb_reg_write = 0;

    // XZR never forwarded
    stall = 1'b0;
    set_id(1, 31, 0, 12, 0, 0, 0, 0, 4'b0010, 1, 0, 0);
    tick();
    stall = 1'b1;
    exmem_reg_write = 1; exmem_rd = 31; exmem_result = 64'hFFFF;
    memwb_reg_write = 1; memwb_rd = 31; memwb_data = 64'h1234;
    #1 chk("xzr_a", alu_a, 64'd0);
    exmem_reg_write = 0; memwb_reg_write = 0;

    // Immediate select with Rm forwarded for the store path
    stall = 1'b0;
    set_id(1, 1, 7, 13, 64'h3, 64'h1, 64'h10, 1, 4'b0010, 0, 0, 1);
    tick();
    stall = 1'b1;
    exmem_reg_write = 1; exmem_rd = 7; exmem_result = 64'h99;
    #1 chk("imm_b", alu_b, 64'h10);
    chk("imm_st", ex_store_data, 64'h99);
    exmem_reg_write = 0;

    // SUB then 3-cycle stall with decode churning
    stall = 1'b0;
    set_id(1, 1, 2, 8, 64'h11, 64'h22, 0, 0, 4'b0110, 1, 0, 0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_random_id();
      tick();
      chk("stall_op", W'(alu_op), W'(4'b0110));
      chk("stall_rd", W'(ex_rd), 64'd8);
      chk("stall_a", alu_a, 64'h11);
      chk("stall_valid", W'(ex_valid), 1);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", W'(ex_valid), '0);
    chk("flush_op", W'(alu_op), '0);
    chk("flush_rw", W'(ex_reg_write), '0);

    // Load-use
    stall = 1'b0;
    set_id(1, 1, 2, 9, 0, 0, 0, 1, 4'b0010, 1, 1, 0);
    tick();
    stall = 1'b1;
    set_id(1, 0, 9, 14, 0, 0, 0, 0, 4'b0010, 1, 0, 0);
    #1 chk("lu_rm", W'(load_use_hazard), 1);
    id_rn_addr = 9; id_rm_addr = 0;
    #1 chk("lu_rn", W'(load_use_hazard), 1);
    id_valid = 0;
    #1 chk("lu_idinv", W'(load_use_hazard), '0);
    stall = 1'b0;
    set_id(1, 1, 2, 31, 0, 0, 0, 1, 4'b0010, 1, 1, 0);
    tick();
    stall = 1'b1;
    set_id(1, 31, 9, 14, 0, 0, 0, 0, 4'b0010, 1, 0, 0);
    #1 chk("lu_xzr", W'(load_use_hazard), '0);
    stall = 1'b0;
    set_id(1, 1, 2, 9, 0, 0, 0, 0, 4'b0010, 1, 0, 0);
    tick();
    set_id(1, 9, 9, 14, 0, 0, 0, 0, 4'b0010, 1, 0, 0);
    #1 chk("lu_noload", W'(load_use_hazard), '0);

    // Invalid capture drops write enables
    set_id(0, 1, 2, 3, 0, 0, 0, 0, 4'b0010, 1, 1, 1);
    tick();
    chk("inv_ctl", W'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}), '0);

    // Reset mid-instruction
    set_id(1, 2, 3, 4, 64'h77, 64'h88, 0, 0, 4'b0110, 1, 0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst2_valid", W'(ex_valid), '0);
    chk("rst2_op", W'(alu_op), '0);
    chk("rst2_rw", W'(ex_reg_write), '0);
    chk("rst2_a", alu_a, '0);
    rst_n = 1'b1;

    // Mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      set_random_id();
      id_rn_addr = pick_reg(); id_rm_addr = pick_reg(); id_rd_addr = pick_reg();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 39) != 0);
      exmem_reg_write = 1'($urandom); exmem_rd = pick_reg();
      exmem_result = {$urandom, $urandom};
      memwb_reg_write = 1'($urandom); memwb_rd = pick_reg();
      memwb_data = {$urandom, $urandom};
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
